// File: rtl/chipset_bus_if.sv
// chipset_bus_if: core-side handshake and peripheral-side select/data signals
// of the chipset bus. The "slave" modport is the bus block itself; the
// "master" modport is its environment (core data port plus peripherals).
interface chipset_bus_if #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NSLV         = 4,
    parameter int unsigned REGION_SHIFT = 8
);
    // core data port
    logic                     req;
    logic                     we;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W-1:0]        rdata;
    logic                     ack;
    logic                     err;
    logic                     busy;

    // peripheral side
    logic [NSLV-1:0]          slv_sel;
    logic                     slv_we;
    logic [REGION_SHIFT-1:0]  slv_addr;
    logic [DATA_W-1:0]        slv_wdata;
    logic [NSLV*DATA_W-1:0]   slv_rdata;
    logic [NSLV-1:0]          slv_rdy;

    modport master (
        output req, we, addr, wdata, slv_rdata, slv_rdy,
        input  rdata, ack, err, busy, slv_sel, slv_we, slv_addr, slv_wdata
    );

    modport slave (
        input  req, we, addr, wdata, slv_rdata, slv_rdy,
        output rdata, ack, err, busy, slv_sel, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/chipset_bus.sv
// chipset_bus: registered, handshaked memory-mapped bus from the core data
// port to NSLV peripheral regions selected by addr[REGION_SHIFT +: log2(NSLV)].
// Unmapped addresses and slaves that stay not-ready for TIMEOUT wait cycles
// complete with ack+err.
// Optional build macro: CHIPSET_ERR_COUNT_EN enables the saturating err_cnt
// error counter; otherwise err_cnt is tied to zero.
module chipset_bus #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NSLV         = 4,
    parameter int unsigned REGION_SHIFT = 8,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        reset,
    chipset_bus_if.slave bus,
    output logic [15:0] err_cnt
);
    localparam int unsigned IDX_W  = $clog2(NSLV);
    localparam int unsigned HI_LSB = REGION_SHIFT + IDX_W;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   slvIdx;
    logic               latWe;
    logic               errPending;
    logic [CNT_W-1:0]   waitCnt;

    logic [IDX_W-1:0]   reqIdx;
    logic               reqMapped;
    logic               selRdy;
    logic [DATA_W-1:0]  selRdata;

    // decode of the live request address (only used in IDLE)
    assign reqIdx    = bus.addr[REGION_SHIFT +: IDX_W];
    assign reqMapped = (bus.addr[ADDR_W-1:HI_LSB] == '0);

    // ready and read data of the latched slave; other slaves are ignored
    always_comb begin
        selRdy   = 1'b0;
        selRdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (slvIdx == IDX_W'(i)) begin
                selRdy   = bus.slv_rdy[i];
                selRdata = bus.slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // transfer FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            slvIdx        <= '0;
            latWe         <= 1'b0;
            errPending    <= 1'b0;
            waitCnt       <= '0;
            bus.rdata     <= '0;
            bus.ack       <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.slv_sel   <= '0;
            bus.slv_we    <= 1'b0;
            bus.slv_addr  <= '0;
            bus.slv_wdata <= '0;
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        latWe         <= bus.we;
                        slvIdx        <= reqIdx;
                        bus.slv_addr  <= bus.addr[REGION_SHIFT-1:0];
                        bus.slv_wdata <= bus.wdata;
                        waitCnt       <= '0;
                        bus.busy      <= 1'b1;
                        if (reqMapped) begin
                            state       <= ACCESS;
                            errPending  <= 1'b0;
                            bus.slv_sel <= NSLV'(1) << reqIdx;
                            bus.slv_we  <= bus.we;
                        end else begin
                            state      <= RESP;
                            errPending <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (selRdy) begin
                        if (!latWe) begin
                            bus.rdata <= selRdata;
                        end
                        bus.slv_sel <= '0;
                        bus.slv_we  <= 1'b0;
                        state       <= RESP;
                    end else if (waitCnt == CNT_W'(TIMEOUT)) begin
                        errPending  <= 1'b1;
                        bus.slv_sel <= '0;
                        bus.slv_we  <= 1'b0;
                        state       <= RESP;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    bus.ack <= 1'b1;
                    bus.err <= errPending;
                    if (errPending && !latWe) begin
                        bus.rdata <= '0;
                    end
                    errPending <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHIPSET_ERR_COUNT_EN
    logic [15:0] errCnt;
    logic        clrHit;

    // accepted write to the all-ones offset of the top region clears the count
    assign clrHit = (state == IDLE) && bus.req && bus.we && reqMapped &&
                    (reqIdx == IDX_W'(NSLV - 1)) && (&bus.addr[REGION_SHIFT-1:0]);

    // saturating count of error responses
    always_ff @(posedge clk) begin
        if (reset) begin
            errCnt <= '0;
        end else if (clrHit) begin
            errCnt <= '0;
        end else if ((state == RESP) && errPending && (errCnt != 16'hFFFF)) begin
            errCnt <= errCnt + 16'd1;
        end
    end

    assign err_cnt = errCnt;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_chipset_bus.sv
// tb_chipset_bus: scenario tasks drive the core port; a negedge slave model
// answers selects after a programmable delay; a scoreboard queue holds the
// expected {err, rdata} of each transfer and is checked on every ack.
module tb_chipset_bus;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NSLV         = 4;
    localparam int unsigned REGION_SHIFT = 8;
    localparam int unsigned TIMEOUT      = 15;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] err_cnt;

    int   total = 0;
    int   bad = 0;
    exp_t scoreQ[$];

    int          rdyDelay[NSLV] = '{0, 0, 0, 0};
    logic [3:0]  noise = 4'b0000;
    int          selCnt = 0;
    logic [31:0] lastRead = 32'h0;
    logic [15:0] expCnt = 16'h0;

    chipset_bus_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .REGION_SHIFT(REGION_SHIFT)
    ) bus ();

    chipset_bus #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV),
        .REGION_SHIFT(REGION_SHIFT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // slave model: selected slave raises ready after rdyDelay wait cycles
    always @(negedge clk) begin
        if (bus.slv_sel != 4'b0) begin
            int idx;
            idx = 0;
            for (int i = 0; i < NSLV; i++) begin
                if (bus.slv_sel[i]) idx = i;
            end
            selCnt++;
            bus.slv_rdy = ((selCnt > rdyDelay[idx]) ? bus.slv_sel : 4'b0) | (noise & ~bus.slv_sel);
        end else begin
            selCnt = 0;
            bus.slv_rdy = noise;
        end
    end

    // scoreboard check on every ack
    always @(negedge clk) begin
        if (bus.ack === 1'b1) begin
            if (scoreQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: ack=1 with no transfer outstanding");
            end else begin
                exp_t e;
                e = scoreQ.pop_front();
                total++;
                if (bus.err !== e.err) begin
                    bad++;
                    $display("FAIL sb_err: got %b expected %b", bus.err, e.err);
                end
                total++;
                if (bus.rdata !== e.rd) begin
                    bad++;
                    $display("FAIL sb_rdata: got %h expected %h", bus.rdata, e.rd);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic doXfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic expErr, input logic [31:0] expRd, input int expLat,
                          input logic [3:0] expSel, input int expHold, input string name);
        int lat;
        int hold;
        bit got;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        scoreQ.push_back('{err: expErr, rd: expRd});
        @(posedge clk); #1;
        bus.req   = 1'b0;
        bus.we    = ~w;
        bus.addr  = 32'hFFFF_FFFF;
        bus.wdata = ~d;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL %s_busy: got %b expected 1", name, bus.busy);
        end
        total++;
        if (bus.slv_sel !== expSel) begin
            bad++; $display("FAIL %s_sel: got %b expected %b", name, bus.slv_sel, expSel);
        end
        if (expSel != 4'b0) begin
            total++;
            if (bus.slv_we !== w || bus.slv_addr !== a[7:0] || bus.slv_wdata !== d) begin
                bad++;
                $display("FAIL %s_slvbus: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                         name, bus.slv_we, bus.slv_addr, bus.slv_wdata, w, a[7:0], d);
            end
        end
        hold = (expSel != 4'b0 && bus.slv_sel === expSel) ? 1 : 0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 300 && !got; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (expSel != 4'b0 && bus.slv_sel === expSel) hold++;
            if (bus.ack === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL %s_noack: got no ack expected ack within 300 cycles", name);
        end
        total++;
        if (lat != expLat) begin
            bad++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, expLat);
        end
        total++;
        if (hold != expHold) begin
            bad++; $display("FAIL %s_selhold: got %0d expected %0d", name, hold, expHold);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL %s_busy_at_ack: got %b expected 0", name, bus.busy);
        end
        total++;
        if (err_cnt !== expCnt) begin
            bad++; $display("FAIL %s_errcnt: got %0d expected %0d", name, err_cnt, expCnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.slv_rdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.ack, bus.err, bus.busy, bus.slv_we} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got ack/err/busy/we=%b expected 0000",
                            {bus.ack, bus.err, bus.busy, bus.slv_we});
        end
        total++;
        if (bus.slv_sel !== 4'b0) begin
            bad++; $display("FAIL reset_sel: got %b expected 0000", bus.slv_sel);
        end
        total++;
        if (bus.rdata !== 32'h0 || bus.slv_wdata !== 32'h0 || bus.slv_addr !== 8'h0) begin
            bad++; $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h expected 0",
                            bus.rdata, bus.slv_wdata, bus.slv_addr);
        end
        total++;
        if (err_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_immediate();
        rdyDelay = '{0, 0, 0, 0};
        doXfer(1'b0, 32'h020, 32'h0, 1'b0, 32'hDEADBEEF, 2, 4'b0001, 1, "read_imm");
        lastRead = 32'hDEADBEEF;
    endtask

    task automatic test_write_wait();
        rdyDelay = '{0, 3, 0, 0};
        doXfer(1'b1, 32'h150, 32'h12345678, 1'b0, lastRead, 5, 4'b0010, 4, "write_wait");
    endtask

    task automatic test_unmapped();
`ifdef CHIPSET_ERR_COUNT_EN
        expCnt = expCnt + 16'd1;
`endif
        doXfer(1'b0, 32'h420, 32'h0, 1'b1, 32'h0, 1, 4'b0000, 0, "unmapped");
        lastRead = 32'h0;
    endtask

    task automatic test_timeout();
        rdyDelay = '{0, 0, 1000, 0};
        noise = 4'b1011;
`ifdef CHIPSET_ERR_COUNT_EN
        expCnt = expCnt + 16'd1;
`endif
        doXfer(1'b0, 32'h220, 32'h0, 1'b1, 32'h0, 2 + TIMEOUT, 4'b0100, TIMEOUT + 1, "timeout");
        noise = 4'b0000;
        rdyDelay = '{0, 0, 0, 0};
    endtask

    task automatic test_reset_mid();
        int acks;
        rdyDelay = '{0, 20, 0, 0};
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h150; bus.wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus.slv_sel !== 4'b0010) begin
            bad++; $display("FAIL rstmid_presel: got %b expected 0010", bus.slv_sel);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({bus.ack, bus.err, bus.busy, bus.slv_we, bus.slv_sel} !== 8'h00) begin
            bad++; $display("FAIL rstmid_ctrl: got ack/err/busy/we/sel=%b expected 0",
                            {bus.ack, bus.err, bus.busy, bus.slv_we, bus.slv_sel});
        end
        total++;
        if (bus.slv_addr !== 8'h0 || bus.slv_wdata !== 32'h0 || bus.rdata !== 32'h0) begin
            bad++; $display("FAIL rstmid_data: got addr=%h wdata=%h rdata=%h expected 0",
                            bus.slv_addr, bus.slv_wdata, bus.rdata);
        end
        expCnt = 16'h0;
        lastRead = 32'h0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.ack === 1'b1) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++; $display("FAIL rstmid_noack: got %0d acks expected 0", acks);
        end
        rdyDelay = '{0, 0, 0, 0};
        doXfer(1'b0, 32'h020, 32'h0, 1'b0, 32'hDEADBEEF, 2, 4'b0001, 1, "after_reset");
        lastRead = 32'hDEADBEEF;
    endtask

    task automatic test_back_to_back();
        int ack1;
        int ack2;
        rdyDelay = '{0, 0, 0, 0};
        ack1 = -1;
        ack2 = -1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h020; bus.wdata = 32'h0;
        scoreQ.push_back('{err: 1'b0, rd: 32'hDEADBEEF});
        scoreQ.push_back('{err: 1'b0, rd: 32'h22222222});
        @(posedge clk); #1;
        bus.addr = 32'h220;
        total++;
        if (bus.slv_sel !== 4'b0001) begin
            bad++; $display("FAIL b2b_sel0: got %b expected 0001", bus.slv_sel);
        end
        for (int i = 1; i <= 20 && ack2 < 0; i++) begin
            @(posedge clk); #1;
            if (bus.ack === 1'b1) begin
                if (ack1 < 0) ack1 = i;
                else ack2 = i;
            end
            if (i == 1 || i == 2) begin
                total++;
                if (bus.slv_sel !== 4'b0000) begin
                    bad++; $display("FAIL b2b_gap%0d: got %b expected 0000", i, bus.slv_sel);
                end
            end
            if (i == 3) begin
                bus.req = 1'b0;
                total++;
                if (bus.slv_sel !== 4'b0100) begin
                    bad++; $display("FAIL b2b_sel1: got %b expected 0100", bus.slv_sel);
                end
            end
        end
        total++;
        if (ack1 != 2) begin
            bad++; $display("FAIL b2b_ack1: got %0d expected 2", ack1);
        end
        total++;
        if (ack2 - ack1 != 3) begin
            bad++; $display("FAIL b2b_spacing: got %0d expected 3", ack2 - ack1);
        end
        lastRead = 32'h22222222;
    endtask

    task automatic test_err_cnt();
        rdyDelay = '{0, 0, 0, 0};
`ifdef CHIPSET_ERR_COUNT_EN
        expCnt = expCnt + 16'd1;
`endif
        doXfer(1'b1, 32'h800, 32'h5A5A5A5A, 1'b1, lastRead, 1, 4'b0000, 0, "errcnt_unmapped");
        doXfer(1'b1, 32'h3FE, 32'h01010101, 1'b0, lastRead, 2, 4'b1000, 1, "errcnt_noclear");
        expCnt = 16'h0;
        doXfer(1'b1, 32'h3FF, 32'h02020202, 1'b0, lastRead, 2, 4'b1000, 1, "errcnt_clear");
    endtask

    initial begin
        bus.slv_rdy = 4'b0;
        test_reset();
        test_read_immediate();
        test_write_wait();
        test_unmapped();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_err_cnt();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (scoreQ.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending expected 0", scoreQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
